// File: rtl/parallel_pe_pipe.sv
// Pipelined parallel processing element: LANES signed products, registered adder
// tree, and a group accumulator with optional saturation and overflow tracking.
module parallel_pe_pipe #(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACCW  = 32,
    parameter int SAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LANES*DW-1:0]     neuron,
    input  logic [LANES*DW-1:0]     weight,
    input  logic [1:0]              ctl,
    input  logic                    vld_i,
    output logic signed [ACCW-1:0]  result,
    output logic                    vld_o,
    output logic                    ovf_o
);

    localparam int LG = $clog2(LANES);
    localparam int PW = 2 * DW;
    localparam int TW = PW + LG;
    localparam int FW = (TW > ACCW) ? TW + 1 : ACCW + 1;

    function automatic logic fits_acc(input logic signed [FW-1:0] v);
        return (&v[FW-1:ACCW-1]) || !(|v[FW-1:ACCW-1]);
    endfunction

    function automatic logic signed [ACCW-1:0] sat_wrap(input logic signed [FW-1:0] v);
        if (fits_acc(v) || (SAT == 0))
            return v[ACCW-1:0];
        else if (v[FW-1])
            return {1'b1, {(ACCW-1){1'b0}}};
        else
            return {1'b0, {(ACCW-1){1'b1}}};
    endfunction

    logic signed [PW-1:0]   w_prod_p0 [LANES];
    logic signed [PW-1:0]   r_prod_p1 [LANES];
    logic                   r_vld_p1;
    logic [1:0]             r_ctl_p1;

    logic signed [TW-1:0]   w_node_p1 [2*LANES-1];
    logic signed [TW-1:0]   r_sum_p2;
    logic                   r_vld_p2;
    logic [1:0]             r_ctl_p2;

    logic signed [ACCW-1:0] w_base_p2;
    logic signed [FW-1:0]   w_full_p2;
    logic                   w_oor_p2;
    logic signed [ACCW-1:0] w_new_p2;
    logic                   w_ovf_p2;

    logic signed [ACCW-1:0] r_psum;
    logic                   r_ovf_acc;
    logic signed [ACCW-1:0] r_result;
    logic                   r_vld_o;
    logic                   r_ovf_o;

    // Stage 1: per-lane signed multiply, operands sign-extended to product width
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [DW-1:0] w_n;
        logic signed [DW-1:0] w_w;
        assign w_n = neuron[g*DW +: DW];
        assign w_w = weight[g*DW +: DW];
        assign w_prod_p0[g] = $signed({{DW{w_n[DW-1]}}, w_n}) * $signed({{DW{w_w[DW-1]}}, w_w});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) r_prod_p1[i] <= '0;
            r_vld_p1 <= 1'b0;
            r_ctl_p1 <= 2'b00;
        end else begin
            r_vld_p1 <= vld_i;
            if (vld_i) begin
                for (int i = 0; i < LANES; i++) r_prod_p1[i] <= w_prod_p0[i];
                r_ctl_p1 <= ctl;
            end else begin
                r_ctl_p1 <= 2'b00;
            end
        end
    end

    // Stage 2: binary adder tree at full width; leaves sit at LANES-1..2*LANES-2
    always_comb begin
        for (int i = 0; i < LANES; i++)
            w_node_p1[LANES-1+i] = {{LG{r_prod_p1[i][PW-1]}}, r_prod_p1[i]};
        for (int k = LANES - 2; k >= 0; k--)
            w_node_p1[k] = w_node_p1[2*k+1] + w_node_p1[2*k+2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_p2 <= '0;
            r_vld_p2 <= 1'b0;
            r_ctl_p2 <= 2'b00;
        end else begin
            r_vld_p2 <= r_vld_p1;
            r_ctl_p2 <= r_ctl_p1;
            if (r_vld_p1) r_sum_p2 <= w_node_p1[0];
        end
    end

    // Stage 3: accumulate with one guard bit beyond the wider of tree and accumulator
    always_comb begin
        w_base_p2 = r_ctl_p2[0] ? '0 : r_psum;
        w_full_p2 = {{(FW-ACCW){w_base_p2[ACCW-1]}}, w_base_p2}
                  + {{(FW-TW){r_sum_p2[TW-1]}}, r_sum_p2};
        w_oor_p2  = ~fits_acc(w_full_p2);
        w_new_p2  = sat_wrap(w_full_p2);
        w_ovf_p2  = (r_ctl_p2[0] ? 1'b0 : r_ovf_acc) | w_oor_p2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psum    <= '0;
            r_ovf_acc <= 1'b0;
            r_result  <= '0;
            r_ovf_o   <= 1'b0;
            r_vld_o   <= 1'b0;
        end else begin
            r_vld_o <= r_vld_p2 & r_ctl_p2[1];
            if (r_vld_p2) begin
                r_psum    <= w_new_p2;
                r_ovf_acc <= w_ovf_p2;
                if (r_ctl_p2[1]) begin
                    r_result <= w_new_p2;
                    r_ovf_o  <= w_ovf_p2;
                end
            end
        end
    end

    assign result = r_result;
    assign vld_o  = r_vld_o;
    assign ovf_o  = r_ovf_o;

endmodule
